// File: rtl/cpu_bus_model_pkg.sv
// Shared constants and types for the 6502 bus environment model.
package cpu_bus_model_pkg;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } rst_state_t;

  localparam logic [15:0] VEC_LO_ADDR = 16'hFFFC;
  localparam logic [15:0] VEC_HI_ADDR = 16'hFFFD;

  // Register offsets inside the 4-byte control window
  localparam logic [1:0] IO_IRQ_ACK  = 2'd0;
  localparam logic [1:0] IO_NMI_TRIG = 2'd1;
  localparam logic [1:0] IO_HALT     = 2'd2;
  localparam logic [1:0] IO_SCRATCH  = 2'd3;

endpackage

// File: rtl/cpu_bus_ram.sv
// Single-port RAM with synchronous write; the preload port takes the single port when selected.
module cpu_bus_ram #(
  parameter int AW = 12
) (
  input  logic          clk_i,
  input  logic          ld_sel_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [7:0]    ld_data_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [7:0]    cpu_data_i,
  output logic [7:0]    rdata_o
);

  logic [7:0]    mem_q [0:(1<<AW)-1];
  logic [AW-1:0] addr;
  logic          we;
  logic [7:0]    wdata;

  always_comb begin
    addr  = cpu_addr_i;
    we    = cpu_we_i;
    wdata = cpu_data_i;
    if (ld_sel_i) begin
      addr  = ld_addr_i;
      we    = 1'b1;
      wdata = ld_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) mem_q[addr] <= wdata;
  end

  // Read-before-write: the top registers this value into d_o at the same edge
  assign rdata_o = mem_q[addr];

endmodule

// File: rtl/cpu_bus_model.sv
// 6502 bus environment: mirrored RAM with preload, reset sequencing, IRQ/NMI generation,
// wait states and run statistics for bring-up of a 6502-compatible core.
module cpu_bus_model
  import cpu_bus_model_pkg::*;
#(
  parameter int          MEM_AW     = 12,
  parameter logic [15:0] RST_VEC    = 16'hF000,
  parameter int          RST_CYC    = 8,
  parameter int          IRQ_PERIOD = 1000,
  parameter int          NMI_LEN    = 2,
  parameter int          WAIT_ST    = 0,
  parameter logic [15:0] IO_BASE    = 16'hBF00
) (
  input  logic              clk_clk_i,
  input  logic              rst_rst_i,
  input  logic [15:0]       a_i,
  input  logic [7:0]        d_i,
  input  logic              rd_i,
  input  logic              wr_i,
  input  logic              sync_i,
  output logic [7:0]        d_o,
  output logic              irq_n_o,
  output logic              nmi_n_o,
  output logic              rdy_o,
  output logic              cpu_rst_n_o,
  input  logic              ld_we_i,
  input  logic [MEM_AW-1:0] ld_addr_i,
  input  logic [7:0]        ld_data_i,
  output logic              done_o,
  output logic [7:0]        status_o,
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       wr_cnt_o
);

  rst_state_t  state_q, state_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic        cpu_rst_n_q, cpu_rst_n_d;
  logic [31:0] irq_cnt_q, irq_cnt_d;
  logic        irq_n_q, irq_n_d;
  logic        irq_wrap;
  logic [31:0] nmi_cnt_q, nmi_cnt_d;
  logic        nmi_n_q, nmi_n_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic        rdy_q, rdy_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic        done_q, done_d;
  logic [7:0]  status_q, status_d;
  logic [7:0]  scratch_q, scratch_d;
  logic [7:0]  d_q, d_d;
  logic [7:0]  ram_rdata;
  logic        io_hit, wr_ok, ram_we, irq_ack, nmi_trig, ld_sel;

  // A CPU bus cycle completes only on an edge where rdy_o=1: writes and opcode fetches
  // presented while rdy_o=0 are ignored and must be held by the CPU until rdy_o returns.
  assign io_hit   = (a_i[15:2] == IO_BASE[15:2]);
  assign wr_ok    = ~rst_rst_i & (state_q == ST_RUN) & wr_i & rdy_q;
  assign ram_we   = wr_ok & ~io_hit;
  assign irq_ack  = wr_ok & io_hit & (a_i[1:0] == IO_IRQ_ACK);
  assign nmi_trig = wr_ok & io_hit & (a_i[1:0] == IO_NMI_TRIG);
  assign ld_sel   = ld_we_i & (state_q == ST_HOLD);

  cpu_bus_ram #(.AW(MEM_AW)) u_ram (
    .clk_i     (clk_clk_i),
    .ld_sel_i  (ld_sel),
    .ld_addr_i (ld_addr_i),
    .ld_data_i (ld_data_i),
    .cpu_we_i  (ram_we),
    .cpu_addr_i(a_i[MEM_AW-1:0]),
    .cpu_data_i(d_i),
    .rdata_o   (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    cpu_rst_n_d = cpu_rst_n_q;
    irq_cnt_d   = irq_cnt_q;
    irq_wrap    = 1'b0;
    irq_n_d     = irq_n_q;
    nmi_cnt_d   = nmi_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    done_d      = done_q;
    status_d    = status_q;
    scratch_d   = scratch_q;
    d_d         = ram_rdata;

    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == 32'(RST_CYC - 1)) begin
          state_d     = ST_RUN;
          cpu_rst_n_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end
      ST_RUN: ;
    endcase

    if (a_i == VEC_LO_ADDR) begin
      d_d = RST_VEC[7:0];
    end else if (a_i == VEC_HI_ADDR) begin
      d_d = RST_VEC[15:8];
    end else if (io_hit) begin
      case (a_i[1:0])
        IO_IRQ_ACK:  d_d = {7'b0, ~irq_n_q};
        IO_NMI_TRIG: d_d = 8'h00;
        IO_HALT:     d_d = status_q;
        default:     d_d = scratch_q;
      endcase
    end

    if (wr_ok) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
      if (io_hit) begin
        case (a_i[1:0])
          IO_HALT: begin
            status_d = d_i;
            done_d   = 1'b1;
          end
          IO_SCRATCH: scratch_d = d_i;
          default: ;
        endcase
      end
    end

    // Period counter freezes once the program has halted
    if (IRQ_PERIOD > 0 && state_q == ST_RUN && !done_q) begin
      if (irq_cnt_q == 32'(IRQ_PERIOD - 1)) begin
        irq_cnt_d = '0;
        irq_wrap  = 1'b1;
      end else begin
        irq_cnt_d = irq_cnt_q + 32'd1;
      end
    end
    if (irq_wrap)     irq_n_d = 1'b0;
    else if (irq_ack) irq_n_d = 1'b1;

    if (nmi_trig)               nmi_cnt_d = 32'(NMI_LEN);
    else if (nmi_cnt_q != '0)   nmi_cnt_d = nmi_cnt_q - 32'd1;
    nmi_n_d = (nmi_cnt_d == '0);

    if (sync_i && rdy_q) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
      wait_cnt_d  = 32'(WAIT_ST);
    end else if (wait_cnt_q != '0) begin
      wait_cnt_d = wait_cnt_q - 32'd1;
    end
    rdy_d = (wait_cnt_d == '0);
  end

  always_ff @(posedge clk_clk_i) begin
    if (rst_rst_i) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      cpu_rst_n_q <= 1'b0;
      irq_cnt_q   <= '0;
      irq_n_q     <= 1'b1;
      nmi_cnt_q   <= '0;
      nmi_n_q     <= 1'b1;
      wait_cnt_q  <= '0;
      rdy_q       <= 1'b1;
      fetch_cnt_q <= '0;
      wr_cnt_q    <= '0;
      done_q      <= 1'b0;
      status_q    <= '0;
      scratch_q   <= '0;
      d_q         <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      irq_cnt_q   <= irq_cnt_d;
      irq_n_q     <= irq_n_d;
      nmi_cnt_q   <= nmi_cnt_d;
      nmi_n_q     <= nmi_n_d;
      wait_cnt_q  <= wait_cnt_d;
      rdy_q       <= rdy_d;
      fetch_cnt_q <= fetch_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      done_q      <= done_d;
      status_q    <= status_d;
      scratch_q   <= scratch_d;
      d_q         <= d_d;
    end
  end

  assign d_o         = d_q;
  assign irq_n_o     = irq_n_q;
  assign nmi_n_o     = nmi_n_q;
  assign rdy_o       = rdy_q;
  assign cpu_rst_n_o = cpu_rst_n_q;
  assign done_o      = done_q;
  assign status_o    = status_q;
  assign fetch_cnt_o = fetch_cnt_q;
  assign wr_cnt_o    = wr_cnt_q;

endmodule

// File: tb/tb_cpu_bus_model.sv
// Bench for cpu_bus_model: directed bus scenarios plus random traffic against a behavioural model.
module tb_cpu_bus_model;

  localparam int          AW         = 12;
  localparam logic [15:0] RST_VEC    = 16'hF000;
  localparam int          RST_CYC    = 8;
  localparam int          IRQ_PERIOD = 10;
  localparam int          NMI_LEN    = 2;
  localparam int          WAIT_ST    = 2;
  localparam logic [15:0] IO_BASE    = 16'hBF00;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_rst_i;
  logic [15:0]   a_i;
  logic [7:0]    d_i;
  logic          rd_i, wr_i, sync_i;
  logic          ld_we_i;
  logic [AW-1:0] ld_addr_i;
  logic [7:0]    ld_data_i;
  logic [7:0]    d_o;
  logic          irq_n_o, nmi_n_o, rdy_o, cpu_rst_n_o, done_o;
  logic [7:0]    status_o;
  logic [31:0]   fetch_cnt_o, wr_cnt_o;

  cpu_bus_model #(
    .MEM_AW(AW), .RST_VEC(RST_VEC), .RST_CYC(RST_CYC), .IRQ_PERIOD(IRQ_PERIOD),
    .NMI_LEN(NMI_LEN), .WAIT_ST(WAIT_ST), .IO_BASE(IO_BASE)
  ) dut (
    .clk_clk_i(clk), .rst_rst_i(rst_rst_i), .a_i(a_i), .d_i(d_i), .rd_i(rd_i),
    .wr_i(wr_i), .sync_i(sync_i), .d_o(d_o), .irq_n_o(irq_n_o), .nmi_n_o(nmi_n_o),
    .rdy_o(rdy_o), .cpu_rst_n_o(cpu_rst_n_o), .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i),
    .ld_data_i(ld_data_i), .done_o(done_o), .status_o(status_o),
    .fetch_cnt_o(fetch_cnt_o), .wr_cnt_o(wr_cnt_o)
  );

  // ---------------- reference model ----------------
  logic [7:0]  m_mem [0:(1<<AW)-1];
  bit          m_run, m_irq_pending, m_done;
  int          m_hold, m_phase, m_nmi_left, m_wait_left;
  logic [7:0]  m_status, m_scratch;
  logic [31:0] m_fetch, m_wr;
  logic [7:0]  exp_q [$];

  int n_checks = 0;
  int n_errors = 0;

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_update();
    bit          pre_run  = m_run;
    bit          pre_rdy  = (m_wait_left == 0);
    bit          pre_done = m_done;
    bit          wr_ok, ack, trig, wrap, io;
    logic [7:0]  rd;
    if (ld_we_i && !pre_run) m_mem[ld_addr_i] = ld_data_i;
    if (rst_rst_i) begin
      m_run = 0; m_hold = 0; m_phase = 0; m_irq_pending = 0; m_done = 0;
      m_nmi_left = 0; m_wait_left = 0; m_status = 0; m_scratch = 0;
      m_fetch = 0; m_wr = 0;
      exp_q.push_back(8'h00);
      return;
    end
    io = (a_i >= IO_BASE) && (a_i <= IO_BASE + 16'd3);
    if (a_i == 16'hFFFC)      rd = RST_VEC[7:0];
    else if (a_i == 16'hFFFD) rd = RST_VEC[15:8];
    else if (io) begin
      case (int'(a_i - IO_BASE))
        0:       rd = m_irq_pending ? 8'h01 : 8'h00;
        1:       rd = 8'h00;
        2:       rd = m_status;
        default: rd = m_scratch;
      endcase
    end else rd = m_mem[int'(a_i) % (1 << AW)];
    exp_q.push_back(rd);

    wr_ok = pre_run && wr_i && pre_rdy;
    ack = 0; trig = 0;
    if (wr_ok) begin
      m_wr = m_wr + 1;
      if (io) begin
        case (int'(a_i - IO_BASE))
          0: ack = 1;
          1: trig = 1;
          2: begin m_status = d_i; m_done = 1; end
          default: m_scratch = d_i;
        endcase
      end else m_mem[int'(a_i) % (1 << AW)] = d_i;
    end

    if (!pre_run) begin
      m_hold++;
      if (m_hold == RST_CYC) m_run = 1;
    end

    wrap = 0;
    if (pre_run && !pre_done) begin
      m_phase++;
      if (m_phase == IRQ_PERIOD) begin m_phase = 0; wrap = 1; end
    end
    if (wrap)     m_irq_pending = 1;
    else if (ack) m_irq_pending = 0;

    if (trig)                m_nmi_left = NMI_LEN;
    else if (m_nmi_left > 0) m_nmi_left--;

    if (sync_i && pre_rdy) begin
      m_fetch = m_fetch + 1;
      m_wait_left = WAIT_ST;
    end else if (m_wait_left > 0) m_wait_left--;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] exp_d;
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check("d_o",         32'(d_o),         32'(exp_d));
    check("irq_n_o",     32'(irq_n_o),     32'(!m_irq_pending));
    check("nmi_n_o",     32'(nmi_n_o),     32'(m_nmi_left == 0));
    check("rdy_o",       32'(rdy_o),       32'(m_wait_left == 0));
    check("cpu_rst_n_o", 32'(cpu_rst_n_o), 32'(m_run));
    check("done_o",      32'(done_o),      32'(m_done));
    check("status_o",    32'(status_o),    32'(m_status));
    check("fetch_cnt_o", fetch_cnt_o,      m_fetch);
    check("wr_cnt_o",    wr_cnt_o,         m_wr);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_idle();
    a_i = 16'hFFFC; d_i = 8'h00; rd_i = 1'b0; wr_i = 1'b0; sync_i = 1'b0; ld_we_i = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] addr);
    a_i = addr; rd_i = 1'b1;
    tick();
    set_idle();
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
    a_i = addr; d_i = data; wr_i = 1'b1;
    tick();
    set_idle();
  endtask

  logic [15:0] io_rd_addrs [6] = '{16'hBF00, 16'hBF01, 16'hBF02, 16'hBF03, 16'hFFFC, 16'hFFFD};
  logic [15:0] io_wr_addrs [3] = '{16'hBF00, 16'hBF01, 16'hBF03};

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  keep_130;
    logic [15:0] ra;
    int          sel;

    set_idle();
    rst_rst_i = 1'b1; ld_addr_i = '0; ld_data_i = 8'h00;
    m_run = 1; m_hold = 0; m_phase = 0; m_irq_pending = 0; m_done = 0;
    m_nmi_left = 0; m_wait_left = 0; m_status = 0; m_scratch = 0; m_fetch = 0; m_wr = 0;

    // Reset state
    repeat (3) tick();
    check("rst_d_o", 32'(d_o), 32'h0);
    check("rst_irq_n", 32'(irq_n_o), 32'h1);
    check("rst_nmi_n", 32'(nmi_n_o), 32'h1);
    check("rst_rdy", 32'(rdy_o), 32'h1);
    check("rst_cpu_rst_n", 32'(cpu_rst_n_o), 32'h0);
    check("rst_done", 32'(done_o), 32'h0);
    check("rst_status", 32'(status_o), 32'h0);
    check("rst_fetch", fetch_cnt_o, 32'h0);
    check("rst_wr", wr_cnt_o, 32'h0);

    // Preload a 64-byte region while the CPU is held in reset
    for (int i = 0; i < 64; i++) begin
      ld_we_i   = 1'b1;
      ld_addr_i = 12'(12'h100 + i);
      ld_data_i = (i == 'h23) ? 8'hA9 : 8'($urandom_range(0, 255));
      tick();
    end
    ld_we_i = 1'b0;
    keep_130 = m_mem[12'h130];

    rst_rst_i = 1'b0;
    for (int k = 1; k <= RST_CYC; k++) begin
      tick();
      check("hold_len", 32'(cpu_rst_n_o), 32'(k == RST_CYC));
    end

    // Vectors, mirroring, preload ignored in RUN
    cpu_read(16'hFFFC); check("vec_lo", 32'(d_o), 32'h00);
    cpu_read(16'hFFFD); check("vec_hi", 32'(d_o), 32'hF0);
    cpu_read(16'h1123); check("mirror_1123", 32'(d_o), 32'hA9);
    a_i = 16'h0123; ld_we_i = 1'b1; ld_addr_i = 12'h123; ld_data_i = 8'h55;
    tick(); set_idle();
    check("rd_0123_a", 32'(d_o), 32'hA9);
    cpu_read(16'h0123); check("ld_in_run_ignored", 32'(d_o), 32'hA9);

    // IRQ request ten cycles into RUN
    for (int r = 6; r <= 9; r++) begin
      cpu_read(IO_BASE);
      check("irq_quiet", 32'(irq_n_o), 32'h1);
    end
    cpu_read(IO_BASE); check("irq_fall", 32'(irq_n_o), 32'h0);
    cpu_read(IO_BASE); check("io_irq_rd", 32'(d_o), 32'h01);
    cpu_write(IO_BASE, 8'h00); check("irq_ack", 32'(irq_n_o), 32'h1);
    repeat (7) tick();
    cpu_write(IO_BASE, 8'h00); check("ack_in_wrap", 32'(irq_n_o), 32'h0);
    cpu_write(IO_BASE, 8'h00); check("irq_ack2", 32'(irq_n_o), 32'h1);

    // NMI pulse and extension
    cpu_write(IO_BASE + 16'd1, 8'h00); check("nmi_p1_c1", 32'(nmi_n_o), 32'h0);
    tick();                            check("nmi_p1_c2", 32'(nmi_n_o), 32'h0);
    tick();                            check("nmi_p1_end", 32'(nmi_n_o), 32'h1);
    cpu_write(IO_BASE + 16'd1, 8'h00); check("nmi_p2_c1", 32'(nmi_n_o), 32'h0);
    cpu_write(IO_BASE + 16'd1, 8'h00); check("nmi_p2_c2", 32'(nmi_n_o), 32'h0);
    tick();                            check("nmi_p2_c3", 32'(nmi_n_o), 32'h0);
    tick();                            check("nmi_p2_end", 32'(nmi_n_o), 32'h1);

    // Wait states and a write stalled by rdy_o=0
    sync_i = 1'b1; tick(); set_idle();
    check("wait_c1", 32'(rdy_o), 32'h0);
    check("fetch_one", fetch_cnt_o, 32'd1);
    a_i = 16'h0130; d_i = 8'h77; wr_i = 1'b1; tick(); set_idle();
    check("wait_c2", 32'(rdy_o), 32'h0);
    tick();
    check("wait_end", 32'(rdy_o), 32'h1);
    check("wr_stalled_cnt", wr_cnt_o, 32'd6);
    cpu_read(16'h0130); check("wr_stalled_ram", 32'(d_o), 32'(keep_130));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      ra  = {4'($urandom_range(0, 15)), 12'(12'h100 + $urandom_range(0, 63))};
      case (sel)
        0, 1, 2, 3: begin a_i = ra; rd_i = 1'b1; end
        4, 5: begin
          a_i = {4'($urandom_range(0, 15)), 12'(12'h100 + $urandom_range(0, 31))};
          d_i = 8'($urandom_range(0, 255)); wr_i = 1'b1;
        end
        6: begin a_i = io_rd_addrs[$urandom_range(0, 5)]; rd_i = 1'b1; end
        7: begin a_i = io_wr_addrs[$urandom_range(0, 2)]; d_i = 8'($urandom_range(0, 255)); wr_i = 1'b1; end
        8: begin a_i = ra; rd_i = 1'b1; sync_i = 1'b1; end
        default: ;
      endcase
      tick();
      set_idle();
    end

    // Halt: status capture, IRQ generation frozen, writes still counted
    repeat (3) tick();
    cpu_write(IO_BASE + 16'd2, 8'h5A);
    check("halt_done", 32'(done_o), 32'h1);
    check("halt_status", 32'(status_o), 32'h5A);
    cpu_write(IO_BASE, 8'h00);
    check("halt_ack", 32'(irq_n_o), 32'h1);
    for (int i = 0; i < 2 * IRQ_PERIOD; i++) begin
      tick();
      check("halt_irq_frozen", 32'(irq_n_o), 32'h1);
    end
    cpu_write(IO_BASE + 16'd3, 8'hC3);
    cpu_read(IO_BASE + 16'd3); check("scratch_rd", 32'(d_o), 32'hC3);

    // Reset in RUN: immediate CPU reset, counters cleared, RAM kept
    rst_rst_i = 1'b1;
    tick();
    check("rerst_cpu_rst_n", 32'(cpu_rst_n_o), 32'h0);
    check("rerst_wr", wr_cnt_o, 32'h0);
    check("rerst_fetch", fetch_cnt_o, 32'h0);
    check("rerst_done", 32'(done_o), 32'h0);
    repeat (2) tick();
    rst_rst_i = 1'b0;
    for (int k = 1; k <= RST_CYC; k++) begin
      tick();
      check("rehold_len", 32'(cpu_rst_n_o), 32'(k == RST_CYC));
    end
    cpu_read(16'h0123); check("ram_kept", 32'(d_o), 32'hA9);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_bus_model.md
Name: cpu_bus_model

Overview:
Parametrised, synthesizable 6502-bus environment model: memory, reset sequencing, interrupt generation and wait states for the R6502_TC core in simulation and FPGA bring-up. It replaces fixed-constant data/control stimulus with a programmable RAM, a preload port, memory-mapped IRQ/NMI/halt control and run statistics. It sits between the bench/loader and the CPU pins (a, d, rd, wr, sync, irq_n, nmi_n, rdy, rst_n).

Parameters:
MEM_AW, 12, RAM address width; depth 2**MEM_AW, mirrored across the 16-bit CPU space
RST_VEC, 16'hF000, value returned at $FFFC/$FFFD
RST_CYC, 8, cycles cpu_rst_n_o is held low after rst_rst_i deasserts (>=1)
IRQ_PERIOD, 1000, cycles between IRQ requests; 0 disables IRQ generation
NMI_LEN, 2, cycles nmi_n_o is held low per trigger (>=1)
WAIT_ST, 0, rdy_o low cycles inserted after each opcode fetch
IO_BASE, 16'hBF00, base of the 4-byte control window (+0 IRQ ack, +1 NMI trigger, +2 halt, +3 scratch)

Ports:
clk_clk_i  in  1  clock
rst_rst_i  in  1  synchronous, active-high reset
a_i  in  16  CPU address
d_i  in  8  CPU write data
rd_i  in  1  CPU read strobe
wr_i  in  1  CPU write strobe
sync_i  in  1  CPU opcode-fetch indicator
d_o  out  8  read data to CPU
irq_n_o  out  1  IRQ to CPU, active low
nmi_n_o  out  1  NMI to CPU, active low
rdy_o  out  1  ready to CPU
cpu_rst_n_o  out  1  CPU reset, active low
ld_we_i  in  1  preload write enable
ld_addr_i  in  MEM_AW  preload address
ld_data_i  in  8  preload data
done_o  out  1  program wrote the halt register
status_o  out  8  data written to the halt register
fetch_cnt_o  out  32  opcode fetches (sync_i & rdy_o)
wr_cnt_o  out  32  CPU writes to RAM or IO

Behaviour:
- Reset values: d_o=0, irq_n_o=1, nmi_n_o=1, rdy_o=1, cpu_rst_n_o=0, done_o=0, status_o=0, counters=0, scratch=0; RAM contents are preserved.
- Reset FSM: HOLD -> RUN. HOLD counts RST_CYC cycles after the last rst_rst_i cycle, then cpu_rst_n_o=1. Reset asserted in any state returns to HOLD.
- Preload: accepted only in HOLD; ld_we_i in RUN is ignored.
- Read path: d_o is registered from the a_i sampled at each edge, so data is valid 1 cycle after the address. Priority order:
  - $FFFC returns RST_VEC[7:0]; $FFFD returns RST_VEC[15:8].
  - IO window: +0 returns {7'b0,~irq_n_o}; +1 returns 0; +2 returns status_o; +3 returns scratch.
  - Otherwise returns RAM[a_i[MEM_AW-1:0]].
  - d_o is updated regardless of rd_i.
- Writes (RUN, wr_i=1, rdy_o=1): IO window decoded first and does not touch RAM; otherwise RAM[a_i[MEM_AW-1:0]] <= d_i. wr_cnt_o increments on every accepted write.
- IRQ: a period counter runs in RUN; on reaching IRQ_PERIOD-1 it wraps and sets irq_n_o=0.
  - irq_n_o stays low until a write to IO+0.
  - Ack and wrap in the same cycle: the request stays pending (irq_n_o=0).
- NMI: a write to IO+1 loads the NMI counter with NMI_LEN, and nmi_n_o=0 while the counter is nonzero. A trigger during an active pulse reloads the counter, extending the pulse.
- Halt: a write to IO+2 captures status_o<=d_i and sets done_o=1 (sticky until reset). After that, wr_cnt_o continues to count, but the IRQ counter freezes.
- Wait states: in the cycle where sync_i=1 & rdy_o=1, the wait counter loads WAIT_ST; rdy_o=0 while the counter is nonzero. WAIT_ST=0 means rdy_o is constantly 1.
- Counters wrap at 2**32 without saturation. Outputs are all registered.

Decomposition:
- Package cpu_bus_model_pkg: IO offset constants, vector addresses $FFFC/$FFFD, FSM state enum {HOLD,RUN}.
- One sub-module, cpu_bus_ram: single-port synchronous RAM, depth 2**MEM_AW, with a mux that selects the preload port or the CPU port.

Test Plan:
- Reset: rst_rst_i 3 cycles, RST_CYC=8 -> cpu_rst_n_o low for exactly 8 cycles after release; reset again mid-RUN -> cpu_rst_n_o=0 next cycle and counters reset.
- Vector and mirror: read $FFFC/$FFFD -> $00/$F0. Preload $0123=$A9, then read $1123 and $0123 (MEM_AW=12) -> $A9 both, one cycle after the address. ld_we_i in RUN writing $0123=$55 -> read still $A9.
- IRQ: IRQ_PERIOD=10 -> irq_n_o falls 10 cycles into RUN, and a read of IO+0 returns $01. Write IO+0 -> irq_n_o=1 next cycle. Ack in the wrap cycle -> irq_n_o stays 0.
- NMI: write IO+1 with NMI_LEN=2 -> nmi_n_o low 2 cycles; second write in the pulse's second cycle -> low 3 cycles total.
- Wait states: WAIT_ST=2, sync_i pulse -> rdy_o low exactly 2 cycles, fetch_cnt_o +1. wr_i during rdy_o=0 -> RAM unchanged and wr_cnt_o unchanged.
- Halt: write $5A to IO+2 -> done_o=1 and status_o=$5A; a following IRQ period elapses -> irq_n_o stays 1.
